// File: rtl/image_pkg.sv
// ---------------------------------------------------------------------------
// image_pkg
// Shared definitions for the image streaming stages: pixel/word widths and
// the AXI4-Stream word carried through the packer's output FIFO.
//   PIX_W, LANES, WORD_W : pixel width, pixels per word, word width
//   axis_word_t          : {last, keep, data} as stored in the FIFO
//   keep_mask()          : byte enables for a word whose final lane is given
// ---------------------------------------------------------------------------
package image_pkg;

    localparam int PIX_W  = 8;
    localparam int LANES  = 4;
    localparam int WORD_W = 32;

    typedef struct packed {
        logic                last;
        logic [LANES-1:0]    keep;
        logic [WORD_W-1:0]   data;
    } axis_word_t;

    // Lanes 0..last_lane are populated; everything above is padding.
    function automatic logic [LANES-1:0] keep_mask(input logic [1:0] last_lane);
        logic [LANES-1:0] mask;
        case (last_lane)
            2'd0:    mask = 4'b0001;
            2'd1:    mask = 4'b0011;
            2'd2:    mask = 4'b0111;
            default: mask = 4'b1111;
        endcase
        return mask;
    endfunction

endpackage

// File: rtl/sync_fifo.sv
// ---------------------------------------------------------------------------
// sync_fifo
// Single-clock first-word-fall-through FIFO, reusable by streaming stages.
//   axi_aclk  : clock (rising edge)
//   axi_reset : synchronous active-high reset, discards all contents
//   wr_en     : push wr_data (ignored when full unless popping that cycle)
//   wr_data   : WIDTH-bit entry
//   rd_en     : pop the head entry (ignored when empty)
//   rd_data   : head entry, valid whenever !empty; reads 0 when empty
//   count     : current number of entries (0..DEPTH)
//   full      : count == DEPTH
//   empty     : count == 0
// DEPTH must be a power of two so the pointers wrap naturally.
// ---------------------------------------------------------------------------
module sync_fifo #(
    parameter int WIDTH = 37,
    parameter int DEPTH = 16
) (
    input  logic                       axi_aclk,
    input  logic                       axi_reset,
    input  logic                       wr_en,
    input  logic [WIDTH-1:0]           wr_data,
    input  logic                       rd_en,
    output logic [WIDTH-1:0]           rd_data,
    output logic [$clog2(DEPTH+1)-1:0] count,
    output logic                       full,
    output logic                       empty
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH+1);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic [CW-1:0]    cnt;
    logic             do_rd;
    logic             do_wr;

    // A pop frees the head slot in the same cycle, so a push is still legal
    // when full as long as a pop accompanies it.
    assign do_rd = rd_en & ~empty;
    assign do_wr = wr_en & (~full | do_rd);

    // Pointer and occupancy bookkeeping.
    always_ff @(posedge axi_aclk) begin
        if (axi_reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            cnt    <= '0;
        end else begin
            if (do_wr) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (do_rd) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            cnt <= cnt + CW'(do_wr) - CW'(do_rd);
        end
    end

    // Storage needs no reset; stale entries are hidden by the empty gate.
    always_ff @(posedge axi_aclk) begin
        if (do_wr) begin
            mem[wr_ptr] <= wr_data;
        end
    end

    assign empty   = (cnt == '0);
    assign full    = (cnt == CW'(DEPTH));
    assign count   = cnt;
    assign rd_data = empty ? '0 : mem[rd_ptr];

endmodule

// File: rtl/image_pixel_packer.sv
// ---------------------------------------------------------------------------
// image_pixel_packer
// Packs the 8-bit pixel stream from the resize stage into 32-bit AXI4-Stream
// words (first pixel in [7:0]), marks the final word of each frame with tlast
// and buffers words in a FIFO so the DMA sink can apply backpressure.
//   axi_aclk, axi_reset : clock, synchronous active-high reset
//   i_out_width/depth   : frame geometry, latched at each frame start (0 = 2^32)
//   i_pixel_data/valid  : pixel input; valid does not wait for ready
//   o_pixel_ready       : pixel will be accepted this cycle
//   o_axis_*            : AXI4-Stream master (tdata, tkeep, tlast, tvalid)
//   i_axis_tready       : sink ready
//   o_overflow          : sticky, a pixel arrived while not ready
//   o_frame_done        : pulse in the cycle the tlast word is pushed
// ---------------------------------------------------------------------------
module image_pixel_packer
    import image_pkg::*;
#(
    parameter int FIFO_DEPTH = 16
) (
    input  logic                axi_aclk,
    input  logic                axi_reset,
    input  logic [31:0]         i_out_width,
    input  logic [31:0]         i_out_depth,
    input  logic [PIX_W-1:0]    i_pixel_data,
    input  logic                i_pixel_valid,
    output logic                o_pixel_ready,
    output logic [WORD_W-1:0]   o_axis_tdata,
    output logic [LANES-1:0]    o_axis_tkeep,
    output logic                o_axis_tlast,
    output logic                o_axis_tvalid,
    input  logic                i_axis_tready,
    output logic                o_overflow,
    output logic                o_frame_done
);

    localparam int CW = $clog2(FIFO_DEPTH+1);

    logic [1:0]        lane_idx;
    logic [31:0]       col;
    logic [31:0]       row;
    logic [31:0]       width_q;
    logic [31:0]       depth_q;
    logic [23:0]       asm_q;
    logic              overflow_q;
    logic              ready_q;

    logic              accept;
    logic              frame_start;
    logic [31:0]       eff_width;
    logic [31:0]       eff_depth;
    logic              col_end;
    logic              row_end;
    logic              last_pix;
    logic              push;
    logic              pop;
    logic              push_en;
    logic [WORD_W-1:0] word_data;
    axis_word_t        push_word;
    axis_word_t        fifo_out;
    logic [CW-1:0]     fifo_count;
    logic [CW-1:0]     count_next;
    logic              fifo_full;
    logic              fifo_empty;

    assign o_pixel_ready = ready_q & ~axi_reset;
    assign accept        = i_pixel_valid & o_pixel_ready;
    assign frame_start   = (col == '0) && (row == '0) && (lane_idx == 2'd0);

    // The first pixel of a frame must already see the new geometry, so the
    // live inputs are used on that pixel and the shadows afterwards.
    assign eff_width = frame_start ? i_out_width : width_q;
    assign eff_depth = frame_start ? i_out_depth : depth_q;

    // Width/depth of 0 wrap to all-ones here, giving 2^32 naturally.
    assign col_end  = (col == eff_width - 32'd1);
    assign row_end  = (row == eff_depth - 32'd1);
    assign last_pix = col_end & row_end;

    assign push    = accept & ((lane_idx == 2'd3) | last_pix);
    assign pop     = o_axis_tvalid & i_axis_tready;
    assign push_en = push & (~fifo_full | pop);

    // Merge the incoming pixel into its lane. Lanes above lane_idx are still
    // zero because the assembly register clears after every push.
    always_comb begin
        word_data = {8'h00, asm_q};
        case (lane_idx)
            2'd0:    word_data[7:0]   = i_pixel_data;
            2'd1:    word_data[15:8]  = i_pixel_data;
            2'd2:    word_data[23:16] = i_pixel_data;
            default: word_data[31:24] = i_pixel_data;
        endcase
        push_word      = '0;
        push_word.data = word_data;
        push_word.keep = keep_mask(lane_idx);
        push_word.last = last_pix;
    end

    assign count_next = fifo_count + CW'(push_en) - CW'(pop);

    // Lane and frame counters, geometry shadows, ready and overflow flags.
    // Ready looks at the occupancy after this cycle's push/pop and keeps one
    // spare slot to cover its own register latency.
    always_ff @(posedge axi_aclk) begin
        if (axi_reset) begin
            lane_idx   <= 2'd0;
            col        <= '0;
            row        <= '0;
            width_q    <= '0;
            depth_q    <= '0;
            asm_q      <= '0;
            overflow_q <= 1'b0;
            ready_q    <= 1'b1;
        end else begin
            ready_q <= (count_next <= CW'(FIFO_DEPTH - 2));
            if (i_pixel_valid && !o_pixel_ready) begin
                overflow_q <= 1'b1;
            end
            if (accept) begin
                if (frame_start) begin
                    width_q <= i_out_width;
                    depth_q <= i_out_depth;
                end
                if (last_pix) begin
                    lane_idx <= 2'd0;
                    col      <= '0;
                    row      <= '0;
                    asm_q    <= '0;
                end else begin
                    lane_idx <= lane_idx + 2'd1;
                    asm_q    <= (lane_idx == 2'd3) ? 24'h0 : word_data[23:0];
                    if (col_end) begin
                        col <= '0;
                        row <= row + 32'd1;
                    end else begin
                        col <= col + 32'd1;
                    end
                end
            end
        end
    end

    sync_fifo #(
        .WIDTH ($bits(axis_word_t)),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .axi_aclk  (axi_aclk),
        .axi_reset (axi_reset),
        .wr_en     (push_en),
        .wr_data   (push_word),
        .rd_en     (pop),
        .rd_data   (fifo_out),
        .count     (fifo_count),
        .full      (fifo_full),
        .empty     (fifo_empty)
    );

    assign o_axis_tvalid = ~fifo_empty;
    assign o_axis_tdata  = fifo_out.data;
    assign o_axis_tkeep  = fifo_out.keep;
    assign o_axis_tlast  = fifo_out.last;
    assign o_overflow    = overflow_q;
    assign o_frame_done  = push & last_pix;

endmodule

// File: tb/tb_image_pixel_packer.sv
// ---------------------------------------------------------------------------
// tb_image_pixel_packer
// Scoreboard bench for image_pixel_packer. The stimulus side feeds pixels and
// a frame-level reference model (pixel index within frame vs width*depth)
// pushes each expected word into a queue; an independent monitor pops and
// compares whenever the DUT hands a word over.
// ---------------------------------------------------------------------------
module tb_image_pixel_packer;

    localparam int FIFO_DEPTH = 16;

    logic        axi_aclk = 1'b0;
    logic        axi_reset;
    logic [31:0] i_out_width;
    logic [31:0] i_out_depth;
    logic [7:0]  i_pixel_data;
    logic        i_pixel_valid;
    logic        o_pixel_ready;
    logic [31:0] o_axis_tdata;
    logic [3:0]  o_axis_tkeep;
    logic        o_axis_tlast;
    logic        o_axis_tvalid;
    logic        i_axis_tready;
    logic        o_overflow;
    logic        o_frame_done;

    int          n_checks = 0;
    int          n_fail   = 0;

    logic [36:0] sb [$];
    logic [7:0]  cur_word [$];
    longint unsigned fr_n     = 0;
    longint unsigned fr_total = 0;
    logic        exp_overflow = 1'b0;
    logic        exp_fd       = 1'b0;
    int          tready_mode  = 0;

    image_pixel_packer #(.FIFO_DEPTH(FIFO_DEPTH)) dut (
        .axi_aclk      (axi_aclk),
        .axi_reset     (axi_reset),
        .i_out_width   (i_out_width),
        .i_out_depth   (i_out_depth),
        .i_pixel_data  (i_pixel_data),
        .i_pixel_valid (i_pixel_valid),
        .o_pixel_ready (o_pixel_ready),
        .o_axis_tdata  (o_axis_tdata),
        .o_axis_tkeep  (o_axis_tkeep),
        .o_axis_tlast  (o_axis_tlast),
        .o_axis_tvalid (o_axis_tvalid),
        .i_axis_tready (i_axis_tready),
        .o_overflow    (o_overflow),
        .o_frame_done  (o_frame_done)
    );

    // 100 MHz clock.
    always #5 axi_aclk = ~axi_aclk;

    // Absolute time limit so a stuck design can never hang the run.
    initial begin
        #400000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: a frame is width*depth pixels (0 = unbounded); a word
    // closes after four pixels or on the frame's final pixel.
    task automatic model_accept(input logic [7:0] d);
        logic [31:0] data;
        logic [3:0]  keep;
        logic        last;
        if (fr_n == 0) begin
            fr_total = 64'(i_out_width) * 64'(i_out_depth);
        end
        cur_word.push_back(d);
        last = (fr_total != 0) && (fr_n == fr_total - 1);
        fr_n++;
        if (cur_word.size() == 4 || last) begin
            data = '0;
            for (int i = 0; i < cur_word.size(); i++) begin
                data |= 32'(cur_word[i]) << (8 * i);
            end
            keep = 4'((1 << cur_word.size()) - 1);
            sb.push_back({last, keep, data});
            cur_word.delete();
        end
        if (last) begin
            fr_n   = 0;
            exp_fd = 1'b1;
        end
    endtask

    // One clock cycle of stimulus. When polite is set the pixel is held back
    // while the model says the block is not ready.
    task automatic applyStimulus(input logic v, input logic [7:0] d, input bit polite, output bit accepted);
        logic exp_ready;
        @(posedge axi_aclk);
        #1;
        exp_ready = ((FIFO_DEPTH - sb.size()) >= 2);
        checkOutput("pixel_ready", 64'(o_pixel_ready), 64'(exp_ready));
        checkOutput("overflow", 64'(o_overflow), 64'(exp_overflow));
        case (tready_mode)
            0:       i_axis_tready = 1'b1;
            1:       i_axis_tready = 1'b0;
            default: i_axis_tready = 1'($urandom_range(0, 1));
        endcase
        accepted = 1'b0;
        exp_fd   = 1'b0;
        if (polite && !exp_ready) begin
            i_pixel_valid = 1'b0;
        end else begin
            i_pixel_valid = v;
        end
        i_pixel_data = d;
        if (i_pixel_valid) begin
            if (exp_ready) begin
                model_accept(d);
                accepted = 1'b1;
            end else begin
                exp_overflow = 1'b1;
            end
        end
        @(negedge axi_aclk);
        checkOutput("frame_done", 64'(o_frame_done), 64'(exp_fd));
    endtask

    task automatic send_pixels(input int n, input logic [7:0] start, input int gap_max);
        bit acc;
        int budget;
        for (int i = 0; i < n; i++) begin
            for (int g = $urandom_range(0, gap_max); g > 0; g--) begin
                applyStimulus(1'b0, 8'h00, 1'b1, acc);
            end
            acc    = 1'b0;
            budget = 500;
            while (!acc && budget > 0) begin
                applyStimulus(1'b1, start + 8'(i), 1'b1, acc);
                budget--;
            end
            if (!acc) begin
                checkOutput("send_timeout", 64'd1, 64'd0);
                return;
            end
        end
    endtask

    task automatic drain();
        bit acc;
        int budget = 300;
        tready_mode = 0;
        while (sb.size() > 0 && budget > 0) begin
            applyStimulus(1'b0, 8'h00, 1'b1, acc);
            budget--;
        end
        applyStimulus(1'b0, 8'h00, 1'b1, acc);
        checkOutput("drain_pending_words", 64'(sb.size()), 64'd0);
    endtask

    // Hold reset for a few cycles with a pixel offered and check every output
    // is quiet; the model drops all in-flight state with the DUT.
    task automatic do_reset();
        @(posedge axi_aclk);
        #1;
        axi_reset     = 1'b1;
        i_pixel_valid = 1'b1;
        i_pixel_data  = 8'hAA;
        i_axis_tready = 1'b0;
        sb.delete();
        cur_word.delete();
        fr_n         = 0;
        exp_overflow = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge axi_aclk);
            checkOutput("rst_tvalid", 64'(o_axis_tvalid), 64'd0);
            checkOutput("rst_tdata", 64'(o_axis_tdata), 64'd0);
            checkOutput("rst_tkeep", 64'(o_axis_tkeep), 64'd0);
            checkOutput("rst_tlast", 64'(o_axis_tlast), 64'd0);
            checkOutput("rst_overflow", 64'(o_overflow), 64'd0);
            checkOutput("rst_frame_done", 64'(o_frame_done), 64'd0);
            checkOutput("rst_pixel_ready", 64'(o_pixel_ready), 64'd0);
        end
        @(posedge axi_aclk);
        #1;
        axi_reset     = 1'b0;
        i_pixel_valid = 1'b0;
    endtask

    // Monitor: compares every handshaken word with the scoreboard head and
    // checks that a stalled word holds steady until it is taken.
    initial begin
        logic        hold_pending = 1'b0;
        logic [36:0] held;
        logic [36:0] got;
        forever begin
            @(negedge axi_aclk);
            if (axi_reset) begin
                hold_pending = 1'b0;
            end else begin
                got = {o_axis_tlast, o_axis_tkeep, o_axis_tdata};
                if (hold_pending) begin
                    checkOutput("stall_tvalid", 64'(o_axis_tvalid), 64'd1);
                    checkOutput("stall_word", 64'(got), 64'(held));
                end
                if (o_axis_tvalid && i_axis_tready) begin
                    if (sb.size() == 0) begin
                        checkOutput("unexpected_word", 64'(got), 64'h0);
                        n_checks++;
                        n_fail++;
                        $display("[TB] FAIL unexpected_word: got 0x%0h, expected no word", got);
                    end else begin
                        checkOutput("word", 64'(got), 64'(sb[0]));
                        void'(sb.pop_front());
                    end
                end
                hold_pending = o_axis_tvalid & ~i_axis_tready;
                held         = got;
            end
        end
    end

    initial begin
        bit acc;
        axi_reset     = 1'b1;
        i_out_width   = 32'd4;
        i_out_depth   = 32'd2;
        i_pixel_data  = 8'h00;
        i_pixel_valid = 1'b0;
        i_axis_tready = 1'b0;

        $display("[TB] reset");
        do_reset();

        $display("[TB] 4x2 frame, back-to-back");
        tready_mode = 0;
        send_pixels(8, 8'h01, 0);
        drain();

        $display("[TB] 3x2 frames, partial final word");
        i_out_width = 32'd3;
        send_pixels(6, 8'h01, 0);
        send_pixels(6, 8'h11, 0);
        drain();

        $display("[TB] width change mid-frame");
        i_out_width = 32'd4;
        send_pixels(3, 8'h21, 0);
        i_out_width = 32'd3;
        send_pixels(5, 8'h24, 0);
        send_pixels(6, 8'h31, 0);
        drain();

        $display("[TB] 64x4 frame, random tready");
        i_out_width = 32'd64;
        i_out_depth = 32'd4;
        tready_mode = 2;
        send_pixels(256, 8'h00, 0);
        drain();

        $display("[TB] random geometry and data");
        for (int f = 0; f < 4; f++) begin
            i_out_width = 32'($urandom_range(1, 9));
            i_out_depth = 32'($urandom_range(1, 4));
            tready_mode = 2;
            for (int p = 0; p < int'(i_out_width * i_out_depth); p++) begin
                send_pixels(1, 8'($urandom), 2);
            end
        end
        drain();

        $display("[TB] reset mid-frame");
        i_out_width = 32'd4;
        i_out_depth = 32'd2;
        tready_mode = 0;
        send_pixels(6, 8'h41, 0);
        do_reset();
        send_pixels(8, 8'h51, 0);
        drain();

        $display("[TB] backpressure and overflow");
        i_out_width = 32'd64;
        i_out_depth = 32'd64;
        tready_mode = 1;
        for (int i = 0; i < 80; i++) begin
            applyStimulus(1'b1, 8'(i), 1'b0, acc);
        end
        checkOutput("bp_words_buffered", 64'(sb.size()), 64'd15);
        drain();
        checkOutput("bp_overflow_sticky", 64'(o_overflow), 64'd1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
